// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | stopwatch_ctrl : button conditioning, run/pause FSM, tick divider  |
// | Optional lap-hold feature enabled by macro STOPWATCH_LAP_EN       |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 100000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_btn,
  input  logic stop_btn,
  input  logic reset_btn,
`ifdef STOPWATCH_LAP_EN
  input  logic lap_btn,
  output logic lap_hold,
`endif
  output logic tick_en,
  output logic clear,
  output logic running,
  output logic paused
);

  localparam int c_pw    = $clog2(TICK_DIV);
  localparam int c_cw    = $clog2(DEB_CYCLES + 1);
  localparam int c_start = 0;
  localparam int c_stop  = 1;
  localparam int c_rst   = 2;
`ifdef STOPWATCH_LAP_EN
  localparam int c_lap   = 3;
  localparam int c_nb    = 4;
`else
  localparam int c_nb    = 3;
`endif
  localparam logic [c_pw-1:0] c_tick_max = c_pw'(TICK_DIV - 1);
  localparam logic [c_cw-1:0] c_deb      = c_cw'(DEB_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2
  } state_t;

  logic [c_nb-1:0] w_raw;
  logic [c_nb-1:0] w_press;

`ifdef STOPWATCH_LAP_EN
  assign w_raw = {lap_btn, reset_btn, stop_btn, start_btn};
`else
  assign w_raw = {reset_btn, stop_btn, start_btn};
`endif

  // Each button: 2-flop synchroniser, stability counter, rising-level pulse.
  for (genvar g = 0; g < c_nb; g++) begin : g_btn
    logic [1:0]      r_sync;
    logic [c_cw-1:0] r_cnt;
    logic            r_level;
    logic            r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync  <= 2'b00;
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_pulse <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], w_raw[g]};
        r_pulse <= 1'b0;
        if (r_sync[1] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_deb) begin
          r_level <= r_sync[1];
          r_cnt   <= '0;
          r_pulse <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_press[g] = r_pulse;
  end

  state_t          r_state, w_state_nxt;
  logic [c_pw-1:0] r_presc, w_presc_nxt;
  logic            r_tick, w_tick_nxt;
  logic            r_clear, w_clear_nxt;
  logic            r_running, r_paused;
`ifdef STOPWATCH_LAP_EN
  logic            r_lap, w_lap_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_clear   <= 1'b0;
      r_running <= 1'b0;
      r_paused  <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      r_lap     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_tick    <= w_tick_nxt;
      r_clear   <= w_clear_nxt;
      r_running <= (w_state_nxt == S_RUNNING);
      r_paused  <= (w_state_nxt == S_PAUSED);
`ifdef STOPWATCH_LAP_EN
      r_lap     <= w_lap_nxt;
`endif
    end
  end

  // The prescaler only advances on cycles that stay in RUNNING, so a stop
  // freezes the partial second and the resume edge does not consume a count.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;
    w_clear_nxt = 1'b0;
`ifdef STOPWATCH_LAP_EN
    w_lap_nxt   = r_lap;
`endif
    if (w_press[c_rst]) begin
      w_state_nxt = S_IDLE;
      w_presc_nxt = '0;
      w_clear_nxt = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_press[c_start]) begin
            w_state_nxt = S_RUNNING;
            w_presc_nxt = '0;
          end
        end
        S_RUNNING: begin
          if (w_press[c_stop]) begin
            w_state_nxt = S_PAUSED;
          end else begin
            if (r_presc == c_tick_max) begin
              w_presc_nxt = '0;
              w_tick_nxt  = 1'b1;
            end else begin
              w_presc_nxt = r_presc + 1'b1;
            end
`ifdef STOPWATCH_LAP_EN
            if (w_press[c_lap] && !w_press[c_start])
              w_lap_nxt = ~r_lap;
`endif
          end
        end
        S_PAUSED: begin
          if (w_press[c_start])
            w_state_nxt = S_RUNNING;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_presc_nxt = '0;
        end
      endcase
    end
`ifdef STOPWATCH_LAP_EN
    if (w_state_nxt == S_IDLE)
      w_lap_nxt = 1'b0;
`endif
  end

  assign tick_en = r_tick;
  assign clear   = r_clear;
  assign running = r_running;
  assign paused  = r_paused;
`ifdef STOPWATCH_LAP_EN
  assign lap_hold = r_lap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_stopwatch_ctrl : directed scoreboard bench for stopwatch_ctrl  |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  localparam int TICK_DIV   = 10;
  localparam int DEB_CYCLES = 4;

  logic clk       = 1'b0;
  logic rst_n     = 1'b1;
  logic start_btn = 1'b0;
  logic stop_btn  = 1'b0;
  logic reset_btn = 1'b0;
  logic tick_en, clear, running, paused;
`ifdef STOPWATCH_LAP_EN
  logic lap_btn = 1'b0;
  logic lap_hold;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int tick_q[$];
  int clear_q[$];

  stopwatch_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_btn (start_btn),
    .stop_btn  (stop_btn),
    .reset_btn (reset_btn),
`ifdef STOPWATCH_LAP_EN
    .lap_btn   (lap_btn),
    .lap_hold  (lap_hold),
`endif
    .tick_en   (tick_en),
    .clear     (clear),
    .running   (running),
    .paused    (paused)
  );

  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Scoreboard side: tick and clear pulses are matched against their expected edge index.
  always @(negedge clk) begin
    if (tick_en)
      check("tick_time", cyc, (tick_q.size() > 0) ? tick_q.pop_front() : -1);
    else if (tick_q.size() > 0 && tick_q[0] <= cyc)
      check("tick_missed_at", cyc, tick_q.pop_front());
    if (clear)
      check("clear_time", cyc, (clear_q.size() > 0) ? clear_q.pop_front() : -1);
    else if (clear_q.size() > 0 && clear_q[0] <= cyc)
      check("clear_missed_at", cyc, clear_q.pop_front());
    check("run_pause_exclusive", 32'(running & paused), 0);
    check("tick_only_running", 32'(tick_en & ~running), 0);
  end

  initial begin
    int k0, s0, r0, q0, a0, b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({tick_en, clear, running, paused}), 0);
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      check("idle_quiet", 32'({tick_en, clear, running, paused}), 0);
    end

    // Short glitches must never be accepted.
    repeat (5) begin
      start_btn = 1'b1;
      repeat (3) @(negedge clk);
      start_btn = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("glitch_stays_idle", 32'({running, paused}), 0);

    // Start: running after edge k0+7, ticks every 10 cycles from k0+17.
    start_btn = 1'b1;
    k0 = cyc + 1;
    for (int j = 1; j <= 5; j++) tick_q.push_back(k0 + 7 + 10 * j);
    wait_cyc(k0 + 6);
    check("start_not_yet", 32'(running), 0);
    @(negedge clk);
    check("start_running", 32'({running, paused}), 32'b10);
    wait_cyc(k0 + 19);
    start_btn = 1'b0;

    // Stop press pulse lands in a cycle where the prescaler holds 6.
    wait_cyc(k0 + 56);
    stop_btn = 1'b1;
    s0 = cyc + 1;
    wait_cyc(s0 + 6);
    check("stop_still_running", 32'({running, paused}), 32'b10);
    @(negedge clk);
    check("stop_paused", 32'({running, paused}), 32'b01);
    wait_cyc(s0 + 10);
    stop_btn = 1'b0;
    wait_cyc(s0 + 47);
    check("paused_hold", 32'({running, paused}), 32'b01);
    check("ticks_before_pause", tick_q.size(), 0);

    // Resume from held count 6: first tick 4 cycles after running returns.
    start_btn = 1'b1;
    r0 = cyc + 1;
    for (int j = 0; j < 3; j++) tick_q.push_back(r0 + 11 + 10 * j);
    wait_cyc(r0 + 6);
    check("resume_not_yet", 32'({running, paused}), 32'b01);
    @(negedge clk);
    check("resume_running", 32'({running, paused}), 32'b10);
    wait_cyc(r0 + 10);
    start_btn = 1'b0;

    // Reset and stop together; the state edge coincides with a would-be tick.
    wait_cyc(r0 + 33);
    reset_btn = 1'b1;
    stop_btn  = 1'b1;
    q0 = cyc + 1;
    clear_q.push_back(q0 + 7);
    wait_cyc(q0 + 6);
    check("prio_still_running", 32'(running), 1);
    @(negedge clk);
    check("prio_idle_clear", 32'({running, paused, clear, tick_en}), 32'b0010);
    @(negedge clk);
    check("prio_clear_one_cycle", 32'({running, paused, clear}), 0);
    wait_cyc(q0 + 14);
    reset_btn = 1'b0;
    stop_btn  = 1'b0;
    repeat (20) @(negedge clk);

    // Async reset while running at prescaler count 5.
    start_btn = 1'b1;
    a0 = cyc + 1;
    wait_cyc(a0 + 7);
    check("run2_running", 32'({running, paused}), 32'b10);
    start_btn = 1'b0;
    wait_cyc(a0 + 12);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({tick_en, clear, running, paused}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("after_async_idle", 32'({running, paused}), 0);

    // Restart must count from 0 again.
    start_btn = 1'b1;
    b0 = cyc + 1;
    tick_q.push_back(b0 + 17);
    tick_q.push_back(b0 + 27);
    wait_cyc(b0 + 7);
    check("run3_running", 32'(running), 1);
    wait_cyc(b0 + 10);
    start_btn = 1'b0;
    wait_cyc(b0 + 30);
    rst_n = 1'b0;
    @(negedge clk);
    check("tick_queue_drained", tick_q.size(), 0);
    check("clear_queue_drained", clear_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
